// File: rtl/result_monitor.sv
// result_monitor
//   Downstream consumer of the shared-multiplier controller. Each accepted
//   result is pushed into a small read-side FIFO, and two limit-alarm state
//   machines (alt high limit, batt low limit) raise an alarm after TRIP_COUNT
//   consecutive violations on their own channel. Samples are taken only while
//   enable is high.
//
//   Optional feature: define RESULT_MON_STATS_EN to add per-channel
//   statistics ports (alt_max, batt_min, alt_cnt, batt_cnt).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   sampling enable
//   in_data    in   signed 16-bit result
//   in_valid   in   result valid
//   in_type    in   0 = alt, 1 = batt
//   rd_en      in   read request, one entry per cycle
//   rd_data    out  registered FIFO head data
//   rd_type    out  type tag of rd_data
//   rd_valid   out  one-cycle pulse when rd_data/rd_type update
//   count      out  entries held
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky: a sample was dropped while full
//   alt_max    out  (stats) signed max of alt samples
//   batt_min   out  (stats) signed min of batt samples
//   alt_cnt    out  (stats) saturating alt sample count
//   batt_cnt   out  (stats) saturating batt sample count
//   alt_alarm  out  alt channel in TRIP
//   batt_alarm out  batt channel in TRIP
//
// Alarm FSM states
//   state    | meaning
//   ST_OK    | no violation run in progress
//   ST_PEND  | violation run shorter than TRIP_COUNT
//   ST_TRIP  | TRIP_COUNT or more consecutive violations, alarm raised
module result_monitor #(
    parameter int                 DEPTH      = 8,
    parameter logic signed [15:0] ALT_LIMIT  = 16'sd100,
    parameter logic signed [15:0] BATT_LOW   = -16'sd10,
    parameter int                 TRIP_COUNT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic signed [15:0]        in_data,
    input  logic                      in_valid,
    input  logic                      in_type,
    input  logic                      rd_en,
    output logic signed [15:0]        rd_data,
    output logic                      rd_type,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
`ifdef RESULT_MON_STATS_EN
    output logic signed [15:0]        alt_max,
    output logic signed [15:0]        batt_min,
    output logic [15:0]               alt_cnt,
    output logic [15:0]               batt_cnt,
`endif
    output logic                      alt_alarm,
    output logic                      batt_alarm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = $clog2(TRIP_COUNT + 1);

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_TRIP = 2'd2;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          sample;
    logic          do_rd;
    logic          do_wr;

    assign sample = in_valid & enable;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_rd  = rd_en & ~empty;
    // While full, a same-cycle read frees the slot being written.
    assign do_wr  = sample & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= {in_type, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_type  <= 1'b0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                {rd_type, rd_data} <= mem[rptr];
                rptr               <= rptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
            if (sample && !do_wr) begin
                overflow <= 1'b1;
            end
        end
    end

    // Channel 0 = alt, channel 1 = batt.
    logic [1:0] viol;
    logic [1:0] adv;
    logic [1:0] alarm_vec;

    assign viol[0] = (in_data > ALT_LIMIT);
    assign viol[1] = (in_data < BATT_LOW);
    assign adv[0]  = sample & ~in_type;
    assign adv[1]  = sample & in_type;

    for (genvar c = 0; c < 2; c++) begin : g_alarm
        logic [1:0]    state;
        logic [VW-1:0] vcnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= ST_OK;
                vcnt  <= '0;
            end else if (adv[c]) begin
                case (state)
                    ST_OK: begin
                        if (viol[c]) begin
                            vcnt  <= VW'(1);
                            state <= (TRIP_COUNT == 1) ? ST_TRIP : ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (viol[c]) begin
                            vcnt <= vcnt + VW'(1);
                            if (vcnt + VW'(1) == VW'(TRIP_COUNT)) begin
                                state <= ST_TRIP;
                            end
                        end else begin
                            state <= ST_OK;
                            vcnt  <= '0;
                        end
                    end
                    ST_TRIP: begin
                        if (!viol[c]) begin
                            state <= ST_OK;
                            vcnt  <= '0;
                        end
                    end
                    default: begin
                        state <= ST_OK;
                        vcnt  <= '0;
                    end
                endcase
            end
        end

        assign alarm_vec[c] = (state == ST_TRIP);
    end

    assign alt_alarm  = alarm_vec[0];
    assign batt_alarm = alarm_vec[1];

`ifdef RESULT_MON_STATS_EN
    // Statistics count every sample of the channel, including dropped ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alt_max  <= 16'sh8000;
            batt_min <= 16'sh7FFF;
            alt_cnt  <= '0;
            batt_cnt <= '0;
        end else begin
            if (adv[0]) begin
                if (in_data > alt_max) begin
                    alt_max <= in_data;
                end
                if (alt_cnt != 16'hFFFF) begin
                    alt_cnt <= alt_cnt + 16'd1;
                end
            end
            if (adv[1]) begin
                if (in_data < batt_min) begin
                    batt_min <= in_data;
                end
                if (batt_cnt != 16'hFFFF) begin
                    batt_cnt <= batt_cnt + 16'd1;
                end
            end
        end
    end
`else
    // Statistics not built in this configuration.
`endif

endmodule

// File: tb/tb_result_monitor.sv
module tb_result_monitor;

    localparam int DEPTH = 8;
    localparam int TRIP  = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_type = 1'b0;
    logic               rd_en = 1'b0;
    logic signed [15:0] rd_data;
    logic               rd_type;
    logic               rd_valid;
    logic [3:0]         count;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               alt_alarm;
    logic               batt_alarm;
`ifdef RESULT_MON_STATS_EN
    logic signed [15:0] alt_max;
    logic signed [15:0] batt_min;
    logic [15:0]        alt_cnt;
    logic [15:0]        batt_cnt;
`endif

    result_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_type    (in_type),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_type    (rd_type),
        .rd_valid   (rd_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
`ifdef RESULT_MON_STATS_EN
        .alt_max    (alt_max),
        .batt_min   (batt_min),
        .alt_cnt    (alt_cnt),
        .batt_cnt   (batt_cnt),
`endif
        .alt_alarm  (alt_alarm),
        .batt_alarm (batt_alarm)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of {type,data}, sticky overflow, and the
    // length of the current violation run per channel.
    logic [16:0]        mq[$];
    bit                 m_ovf;
    logic signed [15:0] m_rd_data;
    bit                 m_rd_type;
    bit                 m_rd_valid;
    int                 run_alt;
    int                 run_batt;
    int                 m_alt_max;
    int                 m_batt_min;
    int                 m_alt_cnt;
    int                 m_batt_cnt;

    task automatic model_reset();
        mq.delete();
        m_ovf      = 0;
        m_rd_data  = '0;
        m_rd_type  = 0;
        m_rd_valid = 0;
        run_alt    = 0;
        run_batt   = 0;
        m_alt_max  = -32768;
        m_batt_min = 32767;
        m_alt_cnt  = 0;
        m_batt_cnt = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        enable   = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive one cycle of stimulus, advance the model, return 1ns after the edge.
    task automatic step(input bit v, input bit t, input int d, input bit r, input bit en = 1'b1);
        bit m_full;
        bit m_empty;
        logic signed [15:0] dd;
        dd = 16'(d);
        @(negedge clk);
        in_valid = v;
        in_type  = t;
        in_data  = dd;
        rd_en    = r;
        enable   = en;
        m_full   = (mq.size() == DEPTH);
        m_empty  = (mq.size() == 0);
        m_rd_valid = 0;
        if (r && !m_empty) begin
            {m_rd_type, m_rd_data} = mq.pop_front();
            m_rd_valid = 1;
        end
        if (v && en) begin
            if (!m_full || r) mq.push_back({t, dd});
            else m_ovf = 1;
            if (!t) begin
                run_alt = (dd > 100) ? run_alt + 1 : 0;
                if (int'(dd) > m_alt_max) m_alt_max = dd;
                if (m_alt_cnt < 65535) m_alt_cnt++;
            end else begin
                run_batt = (dd < -10) ? run_batt + 1 : 0;
                if (int'(dd) < m_batt_min) m_batt_min = dd;
                if (m_batt_cnt < 65535) m_batt_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", full); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        tests++; if ({alt_alarm, batt_alarm} !== 2'b00) begin fails++; $display("FAIL reset_alarms got=%b exp=00", {alt_alarm, batt_alarm}); end
        tests++; if (rd_data !== 16'sd0) begin fails++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        release_reset();
    endtask

    task automatic test_basic_read();
        int exp_d[3] = '{40, 22, 5};
        bit exp_t[3] = '{0, 1, 0};
        apply_reset();
        release_reset();
        step(1, 0, 40, 0);
        step(1, 1, 22, 0);
        step(1, 0, 5, 0);
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL basic_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL basic_rd_valid%0d got=%b exp=1", i, rd_valid); end
            tests++; if (rd_data !== 16'(exp_d[i])) begin fails++; $display("FAIL basic_rd_data%0d got=%0d exp=%0d", i, rd_data, exp_d[i]); end
            tests++; if (rd_type !== exp_t[i]) begin fails++; $display("FAIL basic_rd_type%0d got=%b exp=%b", i, rd_type, exp_t[i]); end
        end
        step(0, 0, 0, 1);
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL empty_rd_valid got=%b exp=0", rd_valid); end
        tests++; if (rd_data !== 16'sd5) begin fails++; $display("FAIL empty_rd_hold got=%0d exp=5", rd_data); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL empty_flag got=%b exp=1", empty); end
        // Latency: sample at one edge, read request at the next, data right after.
        step(1, 1, -77, 0);
        step(0, 0, 0, 1);
        tests++; if (rd_valid !== 1'b1 || rd_data !== -16'sd77 || rd_type !== 1'b1) begin
            fails++; $display("FAIL latency got v=%b d=%0d t=%b exp v=1 d=-77 t=1", rd_valid, rd_data, rd_type);
        end
    endtask

    task automatic test_full_overflow();
        apply_reset();
        release_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, 0, i * 3, 0);
            if (i == 7) begin
                tests++; if (full !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL full_after8 got full=%b cnt=%0d exp full=1 cnt=8", full, count); end
                tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got=%b exp=0", overflow); end
            end
        end
        tests++; if (overflow !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL ovf_drop got ovf=%b cnt=%0d exp ovf=1 cnt=8", overflow, count); end
        step(1, 1, -3, 1);
        tests++; if (count !== 4'd8 || overflow !== 1'b1) begin fails++; $display("FAIL full_rw got cnt=%0d ovf=%b exp cnt=8 ovf=1", count, overflow); end
        tests++; if (rd_valid !== 1'b1 || rd_data !== 16'sd0) begin fails++; $display("FAIL full_rw_data got v=%b d=%0d exp v=1 d=0", rd_valid, rd_data); end
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 0, 1);
            tests++;
            if (i < 8 && (rd_data !== 16'(i * 3) || rd_type !== 1'b0)) begin
                fails++; $display("FAIL drain%0d got d=%0d t=%b exp d=%0d t=0", i, rd_data, rd_type, i * 3);
            end else if (i == 8 && (rd_data !== -16'sd3 || rd_type !== 1'b1)) begin
                fails++; $display("FAIL drain_last got d=%0d t=%b exp d=-3 t=1", rd_data, rd_type);
            end
        end
        step(1, 0, 55, 1);
        tests++; if (rd_valid !== 1'b0 || count !== 4'd1) begin fails++; $display("FAIL empty_rw got v=%b cnt=%0d exp v=0 cnt=1", rd_valid, count); end
    endtask

    task automatic test_alt_alarm();
        int  seq_d[11] = '{120, 130, 150, 100, 120, 130, -17, 90, 101, 101, 101};
        bit  seq_t[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        bit  seq_a[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        apply_reset();
        release_reset();
        for (int i = 0; i < 11; i++) begin
            step(1, seq_t[i], seq_d[i], 1);
            tests++; if (alt_alarm !== seq_a[i]) begin fails++; $display("FAIL alt_alarm%0d got=%b exp=%b", i, alt_alarm, seq_a[i]); end
        end
    endtask

    task automatic test_batt_enable();
        apply_reset();
        release_reset();
        step(1, 1, -17, 0);
        step(1, 1, -17, 0, 0);
        step(1, 1, -17, 0);
        tests++; if (batt_alarm !== 1'b0) begin fails++; $display("FAIL batt_en_gap got=%b exp=0", batt_alarm); end
        tests++; if (count !== 4'd2) begin fails++; $display("FAIL batt_en_count got=%0d exp=2", count); end
        step(1, 1, -17, 0);
        tests++; if (batt_alarm !== 1'b1) begin fails++; $display("FAIL batt_trip got=%b exp=1", batt_alarm); end
        step(1, 1, -10, 0);
        tests++; if (batt_alarm !== 1'b0) begin fails++; $display("FAIL batt_boundary got=%b exp=0", batt_alarm); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        release_reset();
        for (int i = 0; i < 9; i++) step(1, 0, 200, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        tests++; if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || alt_alarm !== 1'b0) begin
            fails++; $display("FAIL mid_reset got cnt=%0d empty=%b ovf=%b alarm=%b exp 0/1/0/0", count, empty, overflow, alt_alarm);
        end
        release_reset();
    endtask

    task automatic test_random();
        int d;
        apply_reset();
        release_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0: d = 100;
                1: d = 101;
                2: d = -10;
                3: d = -11;
                4: d = $urandom_range(101, 400);
                5: d = -$urandom_range(11, 300);
                default: d = $urandom_range(0, 65535) - 32768;
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), d,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0);
            tests++; if (count !== 4'(mq.size())) begin fails++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", i, count, mq.size()); end
            tests++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin fails++; $display("FAIL rnd_flags c%0d got f=%b e=%b exp_cnt=%0d", i, full, empty, mq.size()); end
            tests++; if (overflow !== m_ovf) begin fails++; $display("FAIL rnd_ovf c%0d got=%b exp=%b", i, overflow, m_ovf); end
            tests++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data || rd_type !== m_rd_type) begin
                fails++; $display("FAIL rnd_read c%0d got v=%b d=%0d t=%b exp v=%b d=%0d t=%b", i, rd_valid, rd_data, rd_type, m_rd_valid, m_rd_data, m_rd_type);
            end
            tests++; if (alt_alarm !== (run_alt >= TRIP) || batt_alarm !== (run_batt >= TRIP)) begin
                fails++; $display("FAIL rnd_alarm c%0d got a=%b b=%b exp runs %0d/%0d", i, alt_alarm, batt_alarm, run_alt, run_batt);
            end
`ifdef RESULT_MON_STATS_EN
            tests++; if (int'(alt_max) != m_alt_max || int'(batt_min) != m_batt_min || int'(alt_cnt) != m_alt_cnt || int'(batt_cnt) != m_batt_cnt) begin
                fails++; $display("FAIL rnd_stats c%0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", i, alt_max, batt_min, alt_cnt, batt_cnt, m_alt_max, m_batt_min, m_alt_cnt, m_batt_cnt);
            end
`endif
        end
    endtask

`ifdef RESULT_MON_STATS_EN
    task automatic test_stats();
        apply_reset();
        release_reset();
        step(1, 0, 40, 0);
        step(1, 1, 22, 0);
        step(1, 0, -5, 0);
        step(1, 1, -4, 0);
        step(1, 0, 24, 0);
        tests++; if (alt_max !== 16'sd40 || batt_min !== -16'sd4) begin fails++; $display("FAIL stats_minmax got %0d %0d exp 40 -4", alt_max, batt_min); end
        tests++; if (alt_cnt !== 16'd3 || batt_cnt !== 16'd2) begin fails++; $display("FAIL stats_cnt got %0d %0d exp 3 2", alt_cnt, batt_cnt); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (alt_max !== -16'sd32768 || batt_min !== 16'sd32767 || alt_cnt !== 16'd0 || batt_cnt !== 16'd0) begin
            fails++; $display("FAIL stats_reset got %0d %0d %0d %0d exp -32768 32767 0 0", alt_max, batt_min, alt_cnt, batt_cnt);
        end
        model_reset();
        release_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_read();
        test_full_overflow();
        test_alt_alarm();
        test_batt_enable();
        test_reset_mid();
        test_random();
`ifdef RESULT_MON_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
